bloom_cmd_sequencer: RTL

Command front-end placed directly upstream of the bloom_filter block. It accepts INSERT, QUERY and CLEAR requests on a valid/ready stream and buffers them in a small FIFO. It issues requests one at a time over the filter's start/done handshake, holding key and op stable until done. Each result is returned on a valid/ready response stream with a tag, and the block keeps saturating statistics counters.

---
 rtl/bloom_cmd_sequencer_if.sv | 48 ++++
 rtl/bloom_cmd_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bloom_cmd_sequencer_if.sv
// Request stream, filter start/done handshake and response stream of the bloom command sequencer.
// Latency: none, this is wiring only.
// Backpressure: req_ready/rsp_ready carry the valid-ready stalls; the bf_* pair is a start/done handshake.
interface bloom_cmd_sequencer_if #(
    parameter int KEY_W = 32,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [KEY_W-1:0] req_key;
    logic [TAG_W-1:0] req_tag;

    logic             bf_start;
    logic             bf_op_insert;
    logic             bf_clear_all;
    logic [KEY_W-1:0] bf_key;
    logic             bf_busy;
    logic             bf_done;
    logic             bf_hit;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_op;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_hit;
    logic             rsp_err;

    // Sequencer side.
    modport master (
        input  req_valid, req_op, req_key, req_tag,
        input  bf_busy, bf_done, bf_hit,
        input  rsp_ready,
        output req_ready,
        output bf_start, bf_op_insert, bf_clear_all, bf_key,
        output rsp_valid, rsp_op, rsp_tag, rsp_hit, rsp_err
    );

    // Requester, filter and response-sink side.
    modport slave (
        output req_valid, req_op, req_key, req_tag,
        output bf_busy, bf_done, bf_hit,
        output rsp_ready,
        input  req_ready,
        input  bf_start, bf_op_insert, bf_clear_all, bf_key,
        input  rsp_valid, rsp_op, rsp_tag, rsp_hit, rsp_err
    );
endinterface

// File: rtl/bloom_cmd_sequencer.sv
// Command front-end for bloom_filter: FIFO-buffered INSERT/QUERY/CLEAR, one request in flight.
// Latency: accept to bf_start/bf_clear_all 2 cycles; CLEAR accept to rsp_valid 3 cycles.
// Backpressure: req_ready drops only when the FIFO is full; rsp_* held until rsp_ready.
module bloom_cmd_sequencer #(
    parameter int KEY_W       = 32,
    parameter int TAG_W       = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    bloom_cmd_sequencer_if.master bus,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      cnt_insert,
    output logic [CNT_W-1:0]      cnt_query,
    output logic [CNT_W-1:0]      cnt_hit
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] OP_QUERY  = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, CLR, RESP} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [KEY_W-1:0] key;
        logic [TAG_W-1:0] tag;
    } req_t;

    // Every registered output lives here, alongside the FSM state and hold registers.
    typedef struct packed {
        state_t           state;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [TMO_W-1:0] tmo;
        logic             bf_start;
        logic             bf_op_insert;
        logic             bf_clear_all;
        logic [KEY_W-1:0] bf_key;
        logic             rsp_valid;
        logic [1:0]       rsp_op;
        logic [TAG_W-1:0] rsp_tag;
        logic             rsp_hit;
        logic             rsp_err;
        logic             err_sticky;
        logic [CNT_W-1:0] cnt_insert;
        logic [CNT_W-1:0] cnt_query;
        logic [CNT_W-1:0] cnt_hit;
    } regs_t;

    req_t             mem [FIFO_DEPTH];
    req_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    regs_t            r_q;
    regs_t            r_d;
    logic [TMO_W-1:0] tmo_inc;
    logic             is_query;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Ready depends only on occupancy, never on a same-cycle pop; held low while in reset.
    assign full          = (occ == (PTR_W+1)'(FIFO_DEPTH));
    assign empty         = (occ == '0);
    assign bus.req_ready = !full && !rst;
    assign push          = bus.req_valid && bus.req_ready;
    assign head          = mem[rd_ptr];

    // FIFO payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: bus.req_op, key: bus.req_key, tag: bus.req_tag};
        end
    end

    // FIFO pointers wrap naturally at the power-of-two depth; occ tracks 0..FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (PTR_W+1)'(1);
                2'b01:   occ <= occ - (PTR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // FSM state, hold registers and all outputs; reset drops any in-flight request silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= r_d;
    end

    // Next-state and next-output logic: one request issued at a time, response held until taken.
    always_comb begin
        r_d      = r_q;
        pop      = 1'b0;
        tmo_inc  = r_q.tmo + TMO_W'(1);
        is_query = (r_q.op == OP_QUERY) || (r_q.op == OP_RSVD);
        case (r_q.state)
            IDLE: begin
                if (!empty && !bus.bf_busy) begin
                    pop   = 1'b1;
                    r_d.op  = head.op;
                    r_d.tag = head.tag;
                    if (head.op == OP_CLEAR) begin
                        r_d.bf_clear_all = 1'b1;
                        r_d.state        = CLR;
                    end else begin
                        r_d.bf_start     = 1'b1;
                        r_d.bf_op_insert = (head.op == OP_INSERT);
                        r_d.bf_key       = head.key;
                        r_d.tmo          = '0;
                        r_d.state        = WAIT;
                    end
                end
            end
            WAIT: begin
                r_d.bf_start = 1'b0;
                if (bus.bf_done) begin
                    r_d.rsp_valid = 1'b1;
                    r_d.rsp_op    = r_q.op;
                    r_d.rsp_tag   = r_q.tag;
                    r_d.rsp_hit   = bus.bf_hit && is_query;
                    r_d.rsp_err   = 1'b0;
                    if (is_query) begin
                        r_d.cnt_query = sat_inc(r_q.cnt_query);
                        if (bus.bf_hit) r_d.cnt_hit = sat_inc(r_q.cnt_hit);
                    end else begin
                        r_d.cnt_insert = sat_inc(r_q.cnt_insert);
                    end
                    r_d.state = RESP;
                end else begin
                    r_d.tmo = tmo_inc;
                    if (tmo_inc == TMO_W'(TIMEOUT_CYC)) begin
                        r_d.rsp_valid  = 1'b1;
                        r_d.rsp_op     = r_q.op;
                        r_d.rsp_tag    = r_q.tag;
                        r_d.rsp_hit    = 1'b0;
                        r_d.rsp_err    = 1'b1;
                        r_d.err_sticky = 1'b1;
                        r_d.state      = RESP;
                    end
                end
            end
            CLR: begin
                r_d.bf_clear_all = 1'b0;
                r_d.rsp_valid    = 1'b1;
                r_d.rsp_op       = r_q.op;
                r_d.rsp_tag      = r_q.tag;
                r_d.rsp_hit      = 1'b0;
                r_d.rsp_err      = 1'b0;
                r_d.state        = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    r_d.rsp_valid = 1'b0;
                    r_d.rsp_err   = 1'b0;
                    r_d.state     = IDLE;
                end
            end
            default: r_d.state = IDLE;
        endcase
    end

    assign bus.bf_start     = r_q.bf_start;
    assign bus.bf_op_insert = r_q.bf_op_insert;
    assign bus.bf_clear_all = r_q.bf_clear_all;
    assign bus.bf_key       = r_q.bf_key;
    assign bus.rsp_valid    = r_q.rsp_valid;
    assign bus.rsp_op       = r_q.rsp_op;
    assign bus.rsp_tag      = r_q.rsp_tag;
    assign bus.rsp_hit      = r_q.rsp_hit;
    assign bus.rsp_err      = r_q.rsp_err;
    assign err_sticky       = r_q.err_sticky;
    assign cnt_insert       = r_q.cnt_insert;
    assign cnt_query        = r_q.cnt_query;
    assign cnt_hit          = r_q.cnt_hit;
endmodule
